regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback sources: port A (ALU result) and port B (load/store unit result).
- Each source has a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter moves one buffered write per cycle into a registered write stage. That stage drives the register file write port (we/address/data), which the register file samples on the falling clock edge.
- Also exports a pending-write mask so the hazard logic can stall reads of registers with writes in flight.

---
 rtl/regfile_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: two one-entry holding buffers (ALU and LSU) share the
// register-file write port through a round-robin grant and a registered write stage.
module regfile_wb_arbiter #(
    parameter int WIDTH = 32,
    parameter int INDEX = 5
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  a_valid_in,
    output logic                  a_ready_out,
    input  logic [INDEX-1:0]      a_address_in,
    input  logic [WIDTH-1:0]      a_data_in,
    input  logic                  b_valid_in,
    output logic                  b_ready_out,
    input  logic [INDEX-1:0]      b_address_in,
    input  logic [WIDTH-1:0]      b_data_in,
    output logic                  rf_we_out,
    output logic [INDEX-1:0]      rf_address_out,
    output logic [WIDTH-1:0]      rf_data_out,
    output logic [2**INDEX-1:0]   pending_mask_out
);

    localparam int NREG = 2**INDEX;

    logic             bufVA_q, bufVA_d, bufVB_q, bufVB_d;
    logic [INDEX-1:0] bufAddrA_q, bufAddrA_d, bufAddrB_q, bufAddrB_d;
    logic [WIDTH-1:0] bufDataA_q, bufDataA_d, bufDataB_q, bufDataB_d;
    logic             rr_q, rr_d;
    logic             rfWe_q, rfWe_d;
    logic [INDEX-1:0] rfAddr_q, rfAddr_d;
    logic [WIDTH-1:0] rfData_q, rfData_d;

    logic grantA, grantB, loadA, loadB;

    // Grant depends only on buffer state, so ready never combinationally follows valid.
    assign grantA      = bufVA_q & (~bufVB_q | ~rr_q);
    assign grantB      = bufVB_q & (~bufVA_q | rr_q);
    assign a_ready_out = ~bufVA_q | grantA;
    assign b_ready_out = ~bufVB_q | grantB;
    assign loadA       = a_valid_in & a_ready_out & (a_address_in != '0);
    assign loadB       = b_valid_in & b_ready_out & (b_address_in != '0);

    always_comb begin
        bufVA_d    = bufVA_q;
        bufAddrA_d = bufAddrA_q;
        bufDataA_d = bufDataA_q;
        bufVB_d    = bufVB_q;
        bufAddrB_d = bufAddrB_q;
        bufDataB_d = bufDataB_q;
        rr_d       = rr_q;
        rfWe_d     = grantA | grantB;
        rfAddr_d   = rfAddr_q;
        rfData_d   = rfData_q;

        // A handshake to x0 still frees a granted buffer but loads nothing.
        if (loadA) begin
            bufVA_d    = 1'b1;
            bufAddrA_d = a_address_in;
            bufDataA_d = a_data_in;
        end else if (grantA) begin
            bufVA_d = 1'b0;
        end

        if (loadB) begin
            bufVB_d    = 1'b1;
            bufAddrB_d = b_address_in;
            bufDataB_d = b_data_in;
        end else if (grantB) begin
            bufVB_d = 1'b0;
        end

        if (grantA) begin
            rfAddr_d = bufAddrA_q;
            rfData_d = bufDataA_q;
            rr_d     = 1'b1;
        end else if (grantB) begin
            rfAddr_d = bufAddrB_q;
            rfData_d = bufDataB_q;
            rr_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bufVA_q    <= 1'b0;
            bufAddrA_q <= '0;
            bufDataA_q <= '0;
            bufVB_q    <= 1'b0;
            bufAddrB_q <= '0;
            bufDataB_q <= '0;
            rr_q       <= 1'b0;
            rfWe_q     <= 1'b0;
            rfAddr_q   <= '0;
            rfData_q   <= '0;
        end else begin
            bufVA_q    <= bufVA_d;
            bufAddrA_q <= bufAddrA_d;
            bufDataA_q <= bufDataA_d;
            bufVB_q    <= bufVB_d;
            bufAddrB_q <= bufAddrB_d;
            bufDataB_q <= bufDataB_d;
            rr_q       <= rr_d;
            rfWe_q     <= rfWe_d;
            rfAddr_q   <= rfAddr_d;
            rfData_q   <= rfData_d;
        end
    end

    // Every register with a write buffered or in the write stage; x0 is never pending.
    always_comb begin
        pending_mask_out = '0;
        if (bufVA_q) pending_mask_out[bufAddrA_q] = 1'b1;
        if (bufVB_q) pending_mask_out[bufAddrB_q] = 1'b1;
        if (rfWe_q)  pending_mask_out[rfAddr_q]   = 1'b1;
        pending_mask_out[0] = 1'b0;
    end

    assign rf_we_out      = rfWe_q;
    assign rf_address_out = rfAddr_q;
    assign rf_data_out    = rfData_q;

    logic unusedNreg;
    assign unusedNreg = (NREG == 0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: queue-based reference model checked every
// falling edge, plus directed scenarios with hand-computed expectations.
module tb_regfile_wb_arbiter;

    localparam int WIDTH = 32;
    localparam int INDEX = 5;
    localparam int NREG  = 2**INDEX;

    logic             clk = 1'b0;
    logic             rst;
    logic             aValid = 1'b0, bValid = 1'b0;
    logic             aReady, bReady;
    logic [INDEX-1:0] aAddr = '0, bAddr = '0;
    logic [WIDTH-1:0] aData = '0, bData = '0;
    logic             rfWe;
    logic [INDEX-1:0] rfAddr;
    logic [WIDTH-1:0] rfData;
    logic [NREG-1:0]  pendMask;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter #(.WIDTH(WIDTH), .INDEX(INDEX)) dut (
        .clk_in(clk), .rst_in(rst),
        .a_valid_in(aValid), .a_ready_out(aReady), .a_address_in(aAddr), .a_data_in(aData),
        .b_valid_in(bValid), .b_ready_out(bReady), .b_address_in(bAddr), .b_data_in(bData),
        .rf_we_out(rfWe), .rf_address_out(rfAddr), .rf_data_out(rfData),
        .pending_mask_out(pendMask)
    );

    always #5 clk = ~clk;

    // Reference model: each port owns a queue of at most one write; turnB says B wins a tie.
    typedef struct {
        logic [INDEX-1:0] addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    wr_t              qa[$];
    wr_t              qb[$];
    logic             turnB = 1'b0;
    logic             expWe = 1'b0;
    logic [INDEX-1:0] expAddr = '0;
    logic [WIDTH-1:0] expData = '0;
    logic [WIDTH-1:0] modelRf[NREG];
    logic [WIDTH-1:0] dutRf[NREG];
    logic [WIDTH-1:0] writeLog[$];
    logic             logOn = 1'b0;

    function automatic logic modelWinA();
        return (qa.size() > 0) && (qb.size() == 0 || !turnB);
    endfunction

    function automatic logic modelWinB();
        return (qb.size() > 0) && (qa.size() == 0 || turnB);
    endfunction

    function automatic logic [NREG-1:0] modelMask();
        logic [NREG-1:0] m;
        m = '0;
        foreach (qa[i]) m[qa[i].addr] = 1'b1;
        foreach (qb[i]) m[qb[i].addr] = 1'b1;
        if (expWe) m[expAddr] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    logic mWinA, mWinB, mAccA, mAccB;
    wr_t  mEntry;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            turnB   = 1'b0;
            expWe   = 1'b0;
            expAddr = '0;
            expData = '0;
        end else begin
            mWinA = modelWinA();
            mWinB = modelWinB();
            mAccA = aValid && (qa.size() == 0 || mWinA);
            mAccB = bValid && (qb.size() == 0 || mWinB);
            expWe = mWinA || mWinB;
            if (mWinA) begin
                mEntry  = qa.pop_front();
                expAddr = mEntry.addr;
                expData = mEntry.data;
                turnB   = 1'b1;
            end else if (mWinB) begin
                mEntry  = qb.pop_front();
                expAddr = mEntry.addr;
                expData = mEntry.data;
                turnB   = 1'b0;
            end
            if (mAccA && aAddr != '0) begin
                mEntry.addr = aAddr;
                mEntry.data = aData;
                qa.push_back(mEntry);
            end
            if (mAccB && bAddr != '0) begin
                mEntry.addr = bAddr;
                mEntry.data = bData;
                qb.push_back(mEntry);
            end
        end
    end

    // Compare every cycle, then let both register files commit on the falling edge.
    always @(negedge clk) begin
        checkOutput("rfWe", rfWe, expWe);
        checkOutput("rfAddr", rfAddr, expAddr);
        checkOutput("rfData", rfData, expData);
        checkOutput("aReady", aReady, (qa.size() == 0) || modelWinA());
        checkOutput("bReady", bReady, (qb.size() == 0) || modelWinB());
        checkOutput("pendMask", pendMask, modelMask());
        if (expWe) modelRf[expAddr] = expData;
        if (rfWe) dutRf[rfAddr] = rfData;
        if (rfWe && logOn) writeLog.push_back(rfData);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic av, input logic [INDEX-1:0] aa, input logic [WIDTH-1:0] ad,
                                 input logic bv, input logic [INDEX-1:0] ba, input logic [WIDTH-1:0] bd);
        aValid = av; aAddr = aa; aData = ad;
        bValid = bv; bAddr = ba; bData = bd;
    endtask

    int aCnt, bCnt;
    logic aRdySnap, bRdySnap, orderOk;
    int aSeen, bSeen;

    initial begin
        for (int r = 0; r < NREG; r++) begin
            modelRf[r] = '0;
            dutRf[r]   = '0;
        end
        rst = 1'b1;
        #1;
        checkOutput("resetWe", rfWe, 0);
        checkOutput("resetAddr", rfAddr, 0);
        checkOutput("resetData", rfData, 0);
        checkOutput("resetMask", pendMask, 0);
        checkOutput("resetReadyA", aReady, 1);
        checkOutput("resetReadyB", bReady, 1);
        cycle();
        cycle();
        rst = 1'b0;

        $display("[TB] A-only write");
        applyStimulus(1, 5, 32'h1234, 0, 0, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t1BufWe", rfWe, 0);
        checkOutput("t1BufMask", pendMask, 32'h20);
        cycle();
        checkOutput("t1We", rfWe, 1);
        checkOutput("t1Addr", rfAddr, 5);
        checkOutput("t1Data", rfData, 32'h1234);
        checkOutput("t1Mask", pendMask, 32'h20);
        cycle();
        checkOutput("t1IdleWe", rfWe, 0);
        checkOutput("t1IdleMask", pendMask, 0);
        checkOutput("t1Reg5", dutRf[5], 32'h1234);

        $display("[TB] same address, B favoured");
        applyStimulus(1, 7, 32'h11, 1, 7, 32'h22);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("saMask0", pendMask, 32'h80);
        checkOutput("saReadyA", aReady, 0);
        checkOutput("saReadyB", bReady, 1);
        cycle();
        checkOutput("saFirstData", rfData, 32'h22);
        checkOutput("saMask1", pendMask, 32'h80);
        cycle();
        checkOutput("saSecondData", rfData, 32'h11);
        checkOutput("saMask2", pendMask, 32'h80);
        cycle();
        checkOutput("saMask3", pendMask, 0);
        checkOutput("saDutReg7", dutRf[7], 32'h11);
        checkOutput("saModelReg7", modelRf[7], 32'h11);

        $display("[TB] x0 discard");
        applyStimulus(0, 0, 0, 1, 0, 32'hFFFF);
        checkOutput("x0Ready", bReady, 1);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("x0We0", rfWe, 0);
        checkOutput("x0Mask0", pendMask, 0);
        checkOutput("x0ReadyAfter", bReady, 1);
        cycle();
        checkOutput("x0We1", rfWe, 0);
        checkOutput("x0Mask1", pendMask, 0);

        applyStimulus(0, 0, 0, 1, 10, 32'h10);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        cycle();
        checkOutput("bOnlyAddr", rfAddr, 10);
        cycle();

        $display("[TB] contention");
        applyStimulus(1, 3, 32'hAAAA, 1, 4, 32'hBBBB);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("ctReadyA", aReady, 1);
        checkOutput("ctReadyB", bReady, 0);
        cycle();
        checkOutput("ctFirstAddr", rfAddr, 3);
        checkOutput("ctFirstData", rfData, 32'hAAAA);
        checkOutput("ctReadyB2", bReady, 1);
        cycle();
        checkOutput("ctSecondAddr", rfAddr, 4);
        checkOutput("ctSecondData", rfData, 32'hBBBB);
        cycle();
        checkOutput("ctIdle", rfWe, 0);

        $display("[TB] sustained contention");
        aCnt = 0;
        bCnt = 0;
        writeLog.delete();
        logOn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, INDEX'(1 + aCnt), 32'hA00 + aCnt, 1, INDEX'(16 + bCnt), 32'hB00 + bCnt);
            aRdySnap = aReady;
            bRdySnap = bReady;
            cycle();
            if (aRdySnap) aCnt++;
            if (bRdySnap) bCnt++;
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle();
        logOn = 1'b0;
        checkOutput("susACount", aCnt, 5);
        checkOutput("susBCount", bCnt, 4);
        checkOutput("susWrites", writeLog.size(), 9);
        orderOk = 1'b1;
        aSeen = 0;
        bSeen = 0;
        foreach (writeLog[i]) begin
            if (i % 2 == 0) begin
                if (writeLog[i] != 32'hA00 + aSeen) orderOk = 1'b0;
                aSeen++;
            end else begin
                if (writeLog[i] != 32'hB00 + bSeen) orderOk = 1'b0;
                bSeen++;
            end
        end
        checkOutput("susOrder", orderOk, 1);

        $display("[TB] async reset mid-operation");
        applyStimulus(1, 12, 32'hC, 1, 13, 32'hD);
        cycle();
        applyStimulus(1, 14, 32'hE, 1, 15, 32'hF);
        cycle();
        checkOutput("arWeBefore", rfWe, 1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arWe", rfWe, 0);
        checkOutput("arMask", pendMask, 0);
        checkOutput("arAddr", rfAddr, 0);
        checkOutput("arReadyA", aReady, 1);
        checkOutput("arReadyB", bReady, 1);
        #2;
        rst = 1'b0;
        applyStimulus(1, 9, 32'h99, 1, 20, 32'h20);
        cycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("arPostWe", rfWe, 0);
        checkOutput("arPostReadyB", bReady, 0);
        cycle();
        checkOutput("arPostWe1", rfWe, 1);
        checkOutput("arPostAddr", rfAddr, 9);
        checkOutput("arPostData", rfData, 32'h99);
        cycle();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) != 0,
                          ($urandom_range(0, 3) == 0) ? INDEX'($urandom_range(0, NREG - 1)) : INDEX'($urandom_range(0, 7)),
                          $urandom,
                          $urandom_range(0, 3) != 0,
                          ($urandom_range(0, 3) == 0) ? INDEX'($urandom_range(0, NREG - 1)) : INDEX'($urandom_range(0, 7)),
                          $urandom);
            cycle();
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle();
        for (int r = 0; r < NREG; r++) begin
            checkOutput($sformatf("finalReg%0d", r), dutRf[r], modelRf[r]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
